intr_service: RTL and testbench
===============================

// Module: intr_service
// PURPOSE
//  Services the Ethernet controller interrupt line. On a synchronized falling INTRN it
//  requests the shared register bus, reads ISR, writes the set bits back (write-1-clear),
//  then pulses per-source events. Sits upstream of process control (transEn/recvEn).
//  Its bus outputs drive one RegMaster mux leg into RegIO.
// PARAMETERS
//  ISR_OFFSET      8'h92     controller ISR register offset
//  EVENT_MASK      16'hE800  ISR bits serviced: [15] link, [14] tx, [13] rx, [11] rx-overrun
//  REG_IDLE_STATE  4'd0      RegIO state value meaning "no access in progress"
//  TIMEOUT_CYCLES  255       max cycles waiting for one register access
//  HOLDOFF_CYCLES  16        quiet cycles after a service before INTRN is sampled again
// PORTS
//  clk40m        in   1   system clock, 40 MHz
//  reset         in   1   synchronous reset, active-low
//  INTRN         in   1   controller interrupt, async, active-low
//  bus_req       out  1   request for RegIO ownership
//  bus_gnt       in   1   ownership granted; held high while owned
//  offset        out  8   RegIO register offset
//  length        out  1   RegIO access size: 0 = byte, 1 = word; always 1
//  WR            out  1   RegIO direction: 1 = write, 0 = read
//  writeData     out  16  RegIO write data
//  NewCommand    out  1   one-cycle RegIO start strobe
//  readData      in   16  RegIO read data, valid on access completion
//  state         in   4   RegIO state
//  isr_value     out  16  last ISR read, masked by EVENT_MASK
//  rx_event      out  1   one-cycle pulse: ISR[13] was set
//  tx_event      out  1   one-cycle pulse: ISR[14] was set
//  link_event    out  1   one-cycle pulse: ISR[15] was set
//  ovr_event     out  1   one-cycle pulse: ISR[11] was set
//  timeout_err   out  1   sticky; set on access timeout, cleared only by reset
//  busy          out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0 at a clk40m edge)
//   - All outputs go to 0, except length=1. INTRN synchronizer is preset to 1.
//   - FSM goes to IDLE.
//   - Reset mid-access abandons the access with no clear write.
//  Input sync: INTRN passes through a 2-flop synchronizer. Trigger = sync value low while
//   in IDLE (level-sensitive, so an interrupt still held low is re-serviced after holdoff).
//  Bus signals
//   - offset, WR and writeData are stable from the NewCommand cycle until completion.
//   - Completion = state returns to REG_IDLE_STATE after leaving it post-NewCommand.
//  FSM
//   - IDLE -> REQ on trigger; bus_req=1.
//   - REQ: wait for bus_gnt; no timeout applies here.
//     On gnt: NewCommand=1, offset=ISR_OFFSET, WR=0 -> RD_WAIT.
//   - RD_WAIT: on completion, latch isr = readData & EVENT_MASK.
//     * isr==0 (spurious): -> HOLD with no write.
//     * else: NewCommand=1, WR=1, writeData=isr -> WR_WAIT.
//   - WR_WAIT: on completion -> REPORT.
//   - REPORT: one cycle. Drop bus_req; update isr_value; pulse the event outputs for the
//     set bits, all in the same cycle. -> HOLD.
//   - HOLD: count HOLDOFF_CYCLES with bus_req=0 -> IDLE.
//  Timeout: in RD_WAIT/WR_WAIT, a 9-bit counter (reset on each NewCommand) that reaches
//   TIMEOUT_CYCLES sets timeout_err, drops bus_req, goes to HOLD, and pulses no events.
//  Ownership loss: bus_gnt falling in RD_WAIT/WR_WAIT is treated as a timeout.
//  Latency: trigger to event pulse = 1 (REQ) + grant wait + read + write + 1 (REPORT).
//  Timing: busy is registered; event pulses are never wider than one cycle.
// TESTING
//  1 INTRN low, gnt at once, ISR read 16'h2000 -> write offset 8'h92 data 16'h2000;
//    rx_event one pulse; isr_value=16'h2000.
//  2 ISR read 16'hE800 -> rx, tx, link and ovr pulse in the same cycle;
//    writeData=16'hE800.
//  3 ISR read 16'h0400 (unmasked bit) -> no write cycle, no events; busy falls after
//    HOLDOFF_CYCLES.
//  4 state stuck at non-idle 300 cycles after read NewCommand -> timeout_err=1 at cycle
//    255; bus_req=0.
//  5 bus_gnt withheld 1000 cycles -> bus_req held high, no NewCommand, no timeout_err.
//  6 reset=0 during WR_WAIT -> next cycle all outputs 0, length=1; INTRN still low ->
//    service restarts after release.

Source files
------------

// File: rtl/intr_service_if.sv
// RegIO master-leg bundle: request/grant plus one register access command.
// Latency: none, wires only.
// Backpressure: bus_gnt gates the master; RegIO state paces each access.
`timescale 1ns/1ps
interface intr_service_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [7:0]  offset;
  logic        length;
  logic        WR;
  logic [15:0] writeData;
  logic        NewCommand;
  logic [15:0] readData;
  logic [3:0]  state;

  modport master (
    output bus_req, offset, length, WR, writeData, NewCommand,
    input  bus_gnt, readData, state
  );

  modport slave (
    input  bus_req, offset, length, WR, writeData, NewCommand,
    output bus_gnt, readData, state
  );
endinterface

// File: rtl/intr_service.sv
// Services controller INTRN: read ISR, write-1-clear the serviced bits, pulse per-source events.
// Latency: 2 sync + 1 REQ + grant wait + read + write + 1 REPORT cycles from INTRN fall to pulse.
// Backpressure: waits indefinitely for bus_gnt; each register access bounded by a timeout.
`timescale 1ns/1ps
module intr_service #(
  parameter logic [7:0]  ISR_OFFSET     = 8'h92,
  parameter logic [15:0] EVENT_MASK     = 16'hE800,
  parameter logic [3:0]  REG_IDLE_STATE = 4'd0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          HOLDOFF_CYCLES = 16
) (
  input  logic                  clk40m,
  input  logic                  reset,
  input  logic                  INTRN,
  intr_service_if.master        bus,
  output logic [15:0]           isr_value,
  output logic                  rx_event,
  output logic                  tx_event,
  output logic                  link_event,
  output logic                  ovr_event,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [8:0]    TMO_LAST  = 9'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, RD_WAIT, WR_WAIT, REPORT, HOLD} fsm_t;

  fsm_t          fsm;
  logic          intrn_s1, intrn_s2;
  logic [8:0]    tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic          seen_busy;
  logic [15:0]   isr;
  logic [15:0]   rd_masked;
  logic          access_done;
  logic          tmo_hit;

  // Access is complete once RegIO has left its idle state and come back to it.
  assign access_done = seen_busy && (bus.state == REG_IDLE_STATE);
  // Losing the grant mid-access is handled exactly like running out of time.
  assign tmo_hit     = !bus.bus_gnt || (tmo_cnt == TMO_LAST);
  assign rd_masked   = bus.readData & EVENT_MASK;
  assign bus.length  = 1'b1;

  // Two-flop synchronizer for the asynchronous interrupt, idling at the inactive level.
  always_ff @(posedge clk40m) begin
    if (!reset) begin
      intrn_s1 <= 1'b1;
      intrn_s2 <= 1'b1;
    end else begin
      intrn_s1 <= INTRN;
      intrn_s2 <= intrn_s1;
    end
  end

  // Service sequencer with all bus and event outputs registered.
  always_ff @(posedge clk40m) begin
    if (!reset) begin
      fsm            <= IDLE;
      bus.bus_req    <= 1'b0;
      bus.offset     <= 8'h00;
      bus.WR         <= 1'b0;
      bus.writeData  <= 16'h0000;
      bus.NewCommand <= 1'b0;
      isr            <= 16'h0000;
      isr_value      <= 16'h0000;
      rx_event       <= 1'b0;
      tx_event       <= 1'b0;
      link_event     <= 1'b0;
      ovr_event      <= 1'b0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
      tmo_cnt        <= 9'd0;
      hold_cnt       <= '0;
      seen_busy      <= 1'b0;
    end else begin
      bus.NewCommand <= 1'b0;
      rx_event       <= 1'b0;
      tx_event       <= 1'b0;
      link_event     <= 1'b0;
      ovr_event      <= 1'b0;
      case (fsm)
        IDLE: begin
          if (!intrn_s2) begin
            fsm         <= REQ;
            bus.bus_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            bus.NewCommand <= 1'b1;
            bus.offset     <= ISR_OFFSET;
            bus.WR         <= 1'b0;
            tmo_cnt        <= 9'd0;
            seen_busy      <= 1'b0;
            fsm            <= RD_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (bus.state != REG_IDLE_STATE) seen_busy <= 1'b1;
          if (access_done) begin
            if (fsm == RD_WAIT) begin
              isr <= rd_masked;
              if (rd_masked == 16'h0000) begin
                // Nothing we service is pending: skip the clear write.
                bus.bus_req <= 1'b0;
                hold_cnt    <= '0;
                fsm         <= HOLD;
              end else begin
                bus.NewCommand <= 1'b1;
                bus.WR         <= 1'b1;
                bus.writeData  <= rd_masked;
                tmo_cnt        <= 9'd0;
                seen_busy      <= 1'b0;
                fsm            <= WR_WAIT;
              end
            end else begin
              bus.bus_req <= 1'b0;
              isr_value   <= isr;
              link_event  <= isr[15];
              tx_event    <= isr[14];
              rx_event    <= isr[13];
              ovr_event   <= isr[11];
              fsm         <= REPORT;
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            bus.bus_req <= 1'b0;
            hold_cnt    <= '0;
            fsm         <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 9'd1;
          end
        end
        REPORT: begin
          hold_cnt <= '0;
          fsm      <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            busy <= 1'b0;
            fsm  <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_service.sv
`timescale 1ns/1ps
module tb_intr_service;

  logic        clk40m;
  logic        reset;
  logic        INTRN;
  logic [15:0] isr_value;
  logic        rx_event, tx_event, link_event, ovr_event;
  logic        timeout_err, busy;
  logic [3:0]  evs;

  int vectors;
  int miscompares;

  // Serviced ISR bit positions, in the same order as evs.
  int svc_bits [4] = '{15, 14, 13, 11};

  intr_service_if bus ();

  intr_service dut (
    .clk40m      (clk40m),
    .reset       (reset),
    .INTRN       (INTRN),
    .bus         (bus),
    .isr_value   (isr_value),
    .rx_event    (rx_event),
    .tx_event    (tx_event),
    .link_event  (link_event),
    .ovr_event   (ovr_event),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  assign evs = {link_event, tx_event, rx_event, ovr_event};

  initial clk40m = 1'b0;
  always #12.5 clk40m = ~clk40m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk40m);
  endtask

  // RegIO model for one access: busy for lat cycles, then idle with rdata.
  task automatic access(input logic [15:0] rdata, input int lat);
    logic [7:0]  o;
    logic        w;
    logic [15:0] d;
    int          bad;
    o = bus.offset; w = bus.WR; d = bus.writeData; bad = 0;
    bus.state    = 4'd3;
    bus.readData = 16'($urandom);
    for (int i = 0; i < lat; i++) begin
      step();
      if (bus.NewCommand || bus.offset != o || bus.WR != w || bus.writeData != d ||
          !bus.bus_req || evs != 4'b0) bad++;
    end
    chk("acc_stable", bad, 0);
    bus.state    = 4'd0;
    bus.readData = rdata;
    step();
  endtask

  // One complete interrupt service, checked against the ISR rules.
  task automatic service(input logic [15:0] rd, input int gnt_dly, input int lat);
    logic [15:0] exp_isr;
    logic [3:0]  exp_ev;
    int          n, k, bad;
    exp_isr = 16'h0;
    for (int j = 0; j < 4; j++) begin
      exp_ev[3-j] = rd[svc_bits[j]];
      if (rd[svc_bits[j]]) exp_isr[svc_bits[j]] = 1'b1;
    end
    INTRN = 1'b0;
    n = 0;
    do begin step(); n++; end while (!bus.bus_req && n < 50);
    chk("req_lat", n, 3);
    bad = 0;
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      if (!bus.bus_req || bus.NewCommand || timeout_err) bad++;
    end
    chk("gnt_wait", bad, 0);
    bus.bus_gnt = 1'b1;
    step();
    chk("rd_cmd", bus.NewCommand, 1);
    chk("rd_off", bus.offset, 8'h92);
    chk("rd_wr", bus.WR, 0);
    chk("len", bus.length, 1);
    access(rd, lat);
    if (exp_isr != 16'h0) begin
      chk("wr_cmd", bus.NewCommand, 1);
      chk("wr_wr", bus.WR, 1);
      chk("wr_off", bus.offset, 8'h92);
      chk("wr_dat", bus.writeData, exp_isr);
      access(16'($urandom), $urandom_range(1, 6));
      chk("events", evs, exp_ev);
      chk("isr_val", isr_value, exp_isr);
      chk("rep_req", bus.bus_req, 0);
      INTRN = 1'b1;
      bus.bus_gnt = 1'b0;
      step();
      chk("pulse_w", evs, 0);
    end else begin
      chk("spur_cmd", bus.NewCommand, 0);
      chk("spur_req", bus.bus_req, 0);
      INTRN = 1'b1;
      bus.bus_gnt = 1'b0;
    end
    k = 0; bad = 0;
    while (busy && k < 100) begin
      step(); k++;
      if (bus.NewCommand || evs != 4'b0 || bus.bus_req) bad++;
    end
    chk("holdoff", k, 16);
    chk("hold_quiet", bad, 0);
    chk("tmo_clr", timeout_err, 0);
  endtask

  initial begin
    int n, ev;
    logic [15:0] rd;
    vectors = 0; miscompares = 0;
    reset = 1'b0; INTRN = 1'b1;
    bus.bus_gnt = 1'b0; bus.state = 4'd0; bus.readData = 16'h0;
    repeat (3) step();
    chk("rst_req", bus.bus_req, 0);
    chk("rst_cmd", bus.NewCommand, 0);
    chk("rst_len", bus.length, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_isr", isr_value, 0);
    chk("rst_ev", evs, 0);
    reset = 1'b1;
    repeat (2) step();

    service(16'h2000, 0, 2);
    service(16'hE800, 0, 3);
    service(16'h0400, 0, 2);

    for (int t = 0; t < 24; t++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < 4; j++) rd[svc_bits[j]] = 1'b0;
      service(rd, $urandom_range(0, 5), $urandom_range(1, 8));
    end

    // Grant withheld for a long time: no command, no timeout.
    service(16'hC000, 1000, 4);

    // Access never completes: timeout after 255 cycles.
    INTRN = 1'b0;
    n = 0;
    do begin step(); n++; end while (!bus.bus_req && n < 50);
    chk("t4_req_lat", n, 3);
    bus.bus_gnt = 1'b1;
    step();
    chk("t4_cmd", bus.NewCommand, 1);
    bus.state = 4'd5;
    ev = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (evs != 4'b0) ev++;
      if (i == 254) chk("t4_pre", timeout_err, 0);
      if (i == 255) begin
        chk("t4_tmo", timeout_err, 1);
        chk("t4_req", bus.bus_req, 0);
        INTRN = 1'b1;
        bus.bus_gnt = 1'b0;
      end
      if (i > 255 && bus.bus_req) ev++;
    end
    chk("t4_quiet", ev, 0);
    chk("t4_sticky", timeout_err, 1);
    chk("t4_idle", busy, 0);
    bus.state = 4'd0;
    step();

    // Reset while the clear write is in flight.
    INTRN = 1'b0;
    n = 0;
    do begin step(); n++; end while (!bus.bus_req && n < 50);
    chk("t6_req_lat", n, 3);
    bus.bus_gnt = 1'b1;
    step();
    access(16'h4000, 2);
    chk("t6_wrcmd", bus.NewCommand, 1);
    bus.state = 4'd3;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("t6_req", bus.bus_req, 0);
    chk("t6_cmd", bus.NewCommand, 0);
    chk("t6_off", bus.offset, 0);
    chk("t6_wr", bus.WR, 0);
    chk("t6_wdat", bus.writeData, 0);
    chk("t6_len", bus.length, 1);
    chk("t6_isr", isr_value, 0);
    chk("t6_ev", evs, 0);
    chk("t6_tmo", timeout_err, 0);
    chk("t6_busy", busy, 0);
    bus.state = 4'd0;
    bus.bus_gnt = 1'b0;
    step();
    reset = 1'b1;
    service(16'h8000, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
